// File: rtl/fconvi_mod_if.sv
// Operand/result bundle of the float-to-integer converter.
// Suffixes are from the converter's point of view.
interface fconvi_mod_if;
   logic        en_i;
   logic        clk_en_i;
   logic [81:0] a_i;
   logic [1:0]  rtyp_i;
   logic        is_s_i;
   logic        is32_i;
   logic [1:0]  rm_i;
   logic [64:0] res_o;
   logic [1:0]  excpt_o;
   logic        alt_o;

   modport master (
      output en_i, clk_en_i, a_i, rtyp_i, is_s_i, is32_i, rm_i,
      input  res_o, excpt_o, alt_o
   );

   modport slave (
      input  en_i, clk_en_i, a_i, rtyp_i, is_s_i, is32_i, rm_i,
      output res_o, excpt_o, alt_o
   );
endinterface

// File: rtl/fconvi_mod.sv
// Float-to-integer converter: sngl/dbl/ext register-format operand to a 64- or 32-bit
// signed/unsigned integer. Three stages (decode, align, round/saturate), stalled by clk_en.
module fconvi_mod #(
   parameter logic [15:0] BIAS = 16'h7fff,
   parameter int          LAT  = 3
) (
   input logic         clk,
   input logic         rst,
   fconvi_mod_if.slave bus
);

   localparam logic [1:0] PTYPE_SNGL = 2'd1;
   localparam logic [1:0] PTYPE_DBL  = 2'd2;
   localparam logic [1:0] PTYPE_EXT  = 2'd3;

   localparam logic [64:0] SMAX64 = 65'h0_7FFF_FFFF_FFFF_FFFF;
   localparam logic [64:0] SMIN64 = 65'h1_8000_0000_0000_0000;
   localparam logic [64:0] SMAX32 = 65'h0_0000_0000_7FFF_FFFF;
   localparam logic [64:0] SMIN32 = 65'h1_FFFF_FFFF_8000_0000;
   localparam logic [64:0] UMAX64 = 65'h0_FFFF_FFFF_FFFF_FFFF;
   localparam logic [64:0] UMAX32 = 65'h0_0000_0000_FFFF_FFFF;
   localparam logic [64:0] NLIM64 = 65'h0_8000_0000_0000_0000;
   localparam logic [64:0] NLIM32 = 65'h0_0000_0000_8000_0000;

   typedef struct packed {
      logic        sgn;
      logic [63:0] m;
      logic [15:0] u;
      logic        is_zero;
      logic        zero_inx;
      logic        is_inf;
      logic        is_nan;
      logic        bad_typ;
      logic        is_s;
      logic        is32;
      logic [1:0]  rm;
   } s1_t;

   typedef struct packed {
      logic        sgn;
      logic [63:0] q;
      logic        guard;
      logic        sticky;
      logic        is_zero;
      logic        zero_inx;
      logic        is_inf;
      logic        is_nan;
      logic        bad_typ;
      logic        ovf;
      logic        is_s;
      logic        is32;
      logic [1:0]  rm;
   } s2_t;

   s1_t            s1_d, s1_q;
   s2_t            s2_d, s2_q;
   logic [LAT-1:0] valid_q;
   logic [64:0]    res_d, res_q;
   logic [1:0]     excpt_d, excpt_q;

   logic [15:0]    dec_e;
   logic           exp_zero;
   logic           frac_nz;
   logic [5:0]     sh_amt;
   logic [127:0]   shifted;
   logic           inc;
   logic [64:0]    mag;
   logic           neg;
   logic           in_range;
   logic [64:0]    sat_max, sat_min;

   // A[32] carries nothing in any of the three register formats.
   logic unused_a32;
   assign unused_a32 = bus.a_i[32];

   always_comb begin : p_decode
      // NOTE: every combinational output is defaulted first so no path can infer a latch.
      s1_d      = '0;
      dec_e     = '0;
      exp_zero  = 1'b0;
      frac_nz   = 1'b0;
      s1_d.is_s = bus.is_s_i;
      s1_d.is32 = bus.is32_i;
      s1_d.rm   = bus.rm_i;
      case (bus.rtyp_i)
         PTYPE_EXT: begin
            s1_d.sgn = bus.a_i[80];
            dec_e    = {bus.a_i[81], bus.a_i[65], bus.a_i[79:66]};
            s1_d.m   = {bus.a_i[64:33], bus.a_i[31:0]};
            exp_zero = (dec_e == 16'h0000);
            frac_nz  = |{bus.a_i[64:33], bus.a_i[31:0]};
         end
         PTYPE_DBL: begin
            s1_d.sgn = bus.a_i[63];
            dec_e    = {bus.a_i[62], {5{~bus.a_i[62]}}, bus.a_i[64], bus.a_i[61:53]};
            s1_d.m   = {1'b1, bus.a_i[52:33], bus.a_i[31:0], 11'b0};
            exp_zero = ~|{bus.a_i[62], bus.a_i[64], bus.a_i[61:53]};
            frac_nz  = |{bus.a_i[52:33], bus.a_i[31:0]};
         end
         PTYPE_SNGL: begin
            s1_d.sgn = bus.a_i[31];
            dec_e    = {bus.a_i[30], {8{~bus.a_i[30]}}, bus.a_i[29:23]};
            s1_d.m   = {1'b1, bus.a_i[22:0], 40'b0};
            exp_zero = ~|bus.a_i[30:23];
            frac_nz  = |bus.a_i[22:0];
         end
         default: s1_d.bad_typ = 1'b1;
      endcase
      s1_d.is_zero  = exp_zero;
      s1_d.zero_inx = exp_zero & frac_nz;
      s1_d.is_inf   = (dec_e == 16'hffff) & ~|s1_d.m[62:0];
      s1_d.is_nan   = (dec_e == 16'hffff) &  |s1_d.m[62:0];
      s1_d.u        = dec_e - BIAS;
   end

   always_comb begin : p_align
      s2_d          = '0;
      sh_amt        = 6'd63 - s1_q.u[5:0];
      shifted       = {s1_q.m, 64'b0} >> sh_amt;
      s2_d.sgn      = s1_q.sgn;
      s2_d.is_zero  = s1_q.is_zero;
      s2_d.zero_inx = s1_q.zero_inx;
      s2_d.is_inf   = s1_q.is_inf;
      s2_d.is_nan   = s1_q.is_nan;
      s2_d.bad_typ  = s1_q.bad_typ;
      s2_d.is_s     = s1_q.is_s;
      s2_d.is32     = s1_q.is32;
      s2_d.rm       = s1_q.rm;
      s2_d.ovf      = ~s1_q.u[15] & (|s1_q.u[14:6]);
      if (s1_q.u[15]) begin
         // |value| < 1: only U = -1 can put a set bit in the guard position.
         s2_d.q = '0;
         if (s1_q.u == 16'hffff) begin
            s2_d.guard  = s1_q.m[63];
            s2_d.sticky = |s1_q.m[62:0];
         end else begin
            s2_d.guard  = 1'b0;
            s2_d.sticky = |s1_q.m;
         end
      end else begin
         s2_d.q      = shifted[127:64];
         s2_d.guard  = shifted[63];
         s2_d.sticky = |shifted[62:0];
      end
   end

   always_comb begin : p_round
      case (s2_q.rm)
         2'd0:    inc = s2_q.guard & (s2_q.sticky | s2_q.q[0]);
         2'd1:    inc = 1'b0;
         2'd2:    inc =  s2_q.sgn & (s2_q.guard | s2_q.sticky);
         default: inc = ~s2_q.sgn & (s2_q.guard | s2_q.sticky);
      endcase
      mag = {1'b0, s2_q.q} + {64'b0, inc};
      // A negative value that rounds to zero magnitude is a plain exact-range 0.
      neg = s2_q.sgn & (mag != 65'd0);

      if (s2_q.is_s) begin
         sat_max  = s2_q.is32 ? SMAX32 : SMAX64;
         sat_min  = s2_q.is32 ? SMIN32 : SMIN64;
         in_range = neg ? (mag <= (s2_q.is32 ? NLIM32 : NLIM64)) : (mag <= sat_max);
      end else begin
         sat_max  = s2_q.is32 ? UMAX32 : UMAX64;
         sat_min  = '0;
         in_range = ~neg & (mag <= sat_max);
      end

      res_d   = neg ? (~mag + 65'd1) : mag;
      excpt_d = {1'b0, s2_q.guard | s2_q.sticky};
      if (s2_q.bad_typ) begin
         res_d   = '0;
         excpt_d = 2'b10;
      end else if (s2_q.is_nan) begin
         res_d   = s2_q.is_s ? sat_min : sat_max;
         excpt_d = 2'b10;
      end else if (s2_q.is_zero) begin
         res_d   = '0;
         excpt_d = {1'b0, s2_q.zero_inx};
      end else if (s2_q.is_inf | s2_q.ovf | ~in_range) begin
         res_d   = s2_q.sgn ? sat_min : sat_max;
         excpt_d = 2'b10;
      end
   end

   always_ff @(posedge clk or negedge rst) begin : p_pipe
      // NOTE: data stages are reset as well so a released reset never exposes old operands.
      if (!rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         valid_q <= '0;
         res_q   <= '0;
         excpt_q <= '0;
      end else if (bus.clk_en_i) begin
         // NOTE: non-blocking updates let every stage read the previous cycle's values.
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         valid_q <= {valid_q[LAT-2:0], bus.en_i};
         if (valid_q[LAT-2]) begin
            res_q   <= res_d;
            excpt_q <= excpt_d;
         end
      end
   end

   assign bus.res_o   = res_q;
   assign bus.excpt_o = excpt_q;
   assign bus.alt_o   = valid_q[LAT-1];

endmodule
